// File: rtl/fa_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : fa_coef_loader
// Description : Reloadable BWN alpha coefficient table; stream load, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_coef_loader #(
    parameter int WIDTH_A = 12,
    parameter int DEPTH   = 40,
    parameter int DW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               in_valid_i,
    input  logic [DW-1:0]      in_data_i,
    output logic               in_ready_o,
    output logic               done_o,
    output logic [WIDTH_A-1:0] load_cnt_o,
    input  logic [WIDTH_A-1:0] rd_addr_i,
    output logic [DW-1:0]      rd_coef_o,
    output logic               rd_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the count can reach DEPTH even when DEPTH == 2**WIDTH_A.
    localparam logic [WIDTH_A:0] c_DEPTH = (WIDTH_A+1)'(DEPTH);
    localparam logic [WIDTH_A:0] c_LAST  = (WIDTH_A+1)'(DEPTH - 1);
    localparam logic [WIDTH_A:0] c_ONE   = (WIDTH_A+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH_A:0]  cnt_q, cnt_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     rd_coef_q;
    logic              rd_err_q;

    logic              w_beat;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;
    logic              w_rd_ok;

    assign w_beat   = in_valid_i && (state_q == LOAD);
    assign w_rd_ok  = {1'b0, rd_addr_i} < c_DEPTH;
    assign w_rd_idx = rd_addr_i[AW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_wr_en  = 1'b0;
        w_wr_idx = cnt_q[AW-1:0];
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A start during a load rewinds to entry 0; a same-cycle beat lands there.
                if (start_i) begin
                    w_wr_idx = '0;
                    cnt_d    = w_beat ? c_ONE : '0;
                    w_wr_en  = w_beat;
                    if (w_beat && (DEPTH == 1)) begin
                        state_d = FULL;
                    end
                end else if (w_beat) begin
                    w_wr_en = 1'b1;
                    cnt_d   = cnt_q + c_ONE;
                    if (cnt_q == c_LAST) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read samples mem_q before this edge's write, so a same-entry read sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_coef_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                mem_q[w_wr_idx] <= in_data_i;
            end
            rd_coef_q <= w_rd_ok ? mem_q[w_rd_idx] : '0;
            rd_err_q  <= !w_rd_ok;
        end
    end

    assign in_ready_o = (state_q == LOAD);
    assign done_o     = (state_q == FULL);
    assign load_cnt_o = cnt_q[WIDTH_A-1:0];
    assign rd_coef_o  = rd_coef_q;
    assign rd_err_o   = rd_err_q;

endmodule
`default_nettype wire
